transmissor_serial_8bits: RTL and testbench
===========================================

Name: transmissor_serial_8bits

Overview:
Parallel-in/serial-out transmitter: accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, framed by a serial-valid strobe and a one-cycle done pulse. Unloads, bit by bit, the words held by the team's 8-bit D flip-flop storage register. Feeds serial links and the matching serial-in receiver.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = shift out d[WIDTH-1] first; 0 = shift out d[0] first.

Ports:
clk  input  1  system clock; all state changes on rising edge.
clear  input  1  asynchronous, active-high reset.
d  input  WIDTH  parallel word to transmit.
load_valid  input  1  producer has a word on d.
load_ready  output  1  transmitter can accept a word this cycle.
abort  input  1  synchronous cancel of the word in flight.
serial_out  output  1  current serial bit.
serial_valid  output  1  serial_out carries a valid data bit.
busy  output  1  word in flight (SHIFT or DONE state).
done  output  1  one-cycle pulse after the last bit.
q  output  WIDTH  copy of the last word accepted; held until the next accept.

Behaviour:
- One clock only. Reset is asynchronous and active-high. Clock and reset ports are clk and clear.
- While clear=1, independent of clk: state=IDLE, shift reg=0, bit counter=0, q=0, serial_out=0, serial_valid=0, busy=0, done=0, load_ready=1 (decoded from IDLE).
- All outputs except load_ready are registered. load_ready = (state==IDLE).
- States: IDLE, SHIFT, DONE.
- IDLE: serial_valid=0, serial_out=0. Accept occurs at the rising edge where load_valid=1 and load_ready=1. On accept: shift reg<=d, q<=d, counter<=0, next state SHIFT.
- SHIFT: serial_valid=1 and busy=1.
  - serial_out = shift reg[WIDTH-1] when MSB_FIRST=1; shift reg[0] otherwise.
  - Each edge: shift toward the output end, zero-fill, counter+1.
  - At the edge where counter==WIDTH-1: next state DONE.
  - Bit i is therefore presented during the (i+1)th cycle after the accept edge.
- DONE: done=1, busy=1, serial_valid=0, serial_out=0, load_ready=0. Next edge returns to IDLE unconditionally.
- Latency, accept at edge k: bits appear in cycles k+1..k+WIDTH, done in cycle k+WIDTH+1, load_ready=1 again from cycle k+WIDTH+2.
- load_valid outside IDLE is ignored. d is not sampled and q does not change.
- abort=1 at an edge in SHIFT: next state IDLE, shift reg cleared, no done pulse, q unchanged. abort in IDLE or DONE has no effect.
- abort and load_valid both high in IDLE: the load is accepted (abort ignored).
- clear asserted mid-word: immediate return to reset values. The partial word is lost and no done pulse is produced.
- Counter width: clog2(WIDTH) bits; wraps only via the transition to DONE, never free-running.

Decomposition:
- Shared package/include: state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default WIDTH. The same encodings are reused by the receiver.
- One natural sub-module: shift_reg_piso (WIDTH-bit loadable shift register with direction parameter and async clear). The FSM and counter stay in the top.

Test Plan:
- Clock 20 ns. Assert clear for 2 cycles -> load_ready=1; q, serial_out, serial_valid, busy, done all 0.
- MSB_FIRST=1, d=8'b10110010, load_valid pulsed one cycle -> serial_out over 8 valid cycles = 1,0,1,1,0,0,1,0; q=8'hB2; done high exactly in cycle 9 after accept; load_ready=1 in cycle 10.
- MSB_FIRST=0, d=8'b00000001 -> serial sequence 1,0,0,0,0,0,0,0; done after 8 bits.
- load_valid held high with d=8'hFF then 8'h55 changed mid-word -> 8'hFF is sent intact and q stays FF. 8'h55 is accepted only at the first IDLE edge; q=8'h55 afterwards.
- abort asserted on the 4th bit of d=8'hF0 -> serial_valid drops next cycle, no done pulse, load_ready=1, q=8'hF0.
- clear asserted asynchronously (between edges) during bit 5 -> all outputs return to reset values immediately. The next load of 8'hAA transmits correctly from bit 0.

Source files
------------

// File: rtl/transmissor_serial_8bits_pkg.sv
// transmissor_serial_8bits_pkg: state encodings and default width shared by transmitter and receiver
package transmissor_serial_8bits_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/transmissor_serial_8bits_if.sv
// transmissor_serial_8bits_if: load handshake and serial output bundle
interface transmissor_serial_8bits_if import transmissor_serial_8bits_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             abort;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  modport master (
    output d, load_valid, abort,
    input  load_ready, serial_out, serial_valid, busy, done, q
  );
  modport slave (
    input  d, load_valid, abort,
    output load_ready, serial_out, serial_valid, busy, done, q
  );
endinterface

// File: rtl/transmissor_serial_8bits_shift_reg_piso.sv
// shift_reg_piso: loadable parallel-in/serial-out shift register, zero-filling
module shift_reg_piso #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic             sout
);
  logic [WIDTH-1:0] sr;
  // flush wins over load, load over shift; shifting moves data toward the output end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) sr <= '0;
    else if (flush) sr <= '0;
    else if (load) sr <= d;
    else if (shift) sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
  end
  assign sout = MSB_FIRST ? sr[WIDTH-1] : sr[0];
endmodule

// File: rtl/transmissor_serial_8bits.sv
// transmissor_serial_8bits: valid/ready loaded word shifted out one bit per clock with done pulse
module transmissor_serial_8bits import transmissor_serial_8bits_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                       clk,
  input logic                       clear,
  transmissor_serial_8bits_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           state, next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_r;
  logic             accept, shift, flush, sout;
  // state register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else state <= next;
  end
  // next-state and shift-register controls; abort only matters mid-word
  always_comb begin
    next   = state;
    accept = 1'b0;
    shift  = 1'b0;
    flush  = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.load_valid;
        next   = bus.load_valid ? SHIFT : IDLE;
      end
      SHIFT: begin
        flush = bus.abort;
        shift = !bus.abort;
        next  = bus.abort ? IDLE : (cnt == CW'(WIDTH - 1)) ? DONE : SHIFT;
      end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // bit counter restarts on accept/abort and only advances while shifting
  always_ff @(posedge clk or posedge clear) begin
    if (clear) cnt <= '0;
    else if (accept || flush) cnt <= '0;
    else if (shift) cnt <= cnt + 1'b1;
  end
  // copy of the last accepted word
  always_ff @(posedge clk or posedge clear) begin
    if (clear) q_r <= '0;
    else if (accept) q_r <= bus.d;
  end
  shift_reg_piso #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk(clk), .clear(clear), .load(accept), .shift(shift), .flush(flush), .d(bus.d), .sout(sout)
  );
  assign bus.load_ready   = state == IDLE;
  assign bus.busy         = state != IDLE;
  assign bus.serial_valid = state == SHIFT;
  assign bus.done         = state == DONE;
  assign bus.serial_out   = (state == SHIFT) && sout;
  assign bus.q            = q_r;
endmodule

// File: tb/tb_transmissor_serial_8bits.sv
// tb_transmissor_serial_8bits: directed checks of MSB-first and LSB-first transmitters
module tb_transmissor_serial_8bits;
  logic clk = 1'b0;
  logic clear = 1'b1;
  int checks = 0;
  int errors = 0;
  transmissor_serial_8bits_if #(.WIDTH(8)) bm();
  transmissor_serial_8bits_if #(.WIDTH(8)) bl();
  transmissor_serial_8bits #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .clear(clear), .bus(bm));
  transmissor_serial_8bits #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .clear(clear), .bus(bl));
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bm.d = '0; bm.load_valid = 0; bm.abort = 0;
    bl.d = '0; bl.load_valid = 0; bl.abort = 0;
    clear = 1;
    step(); step();
    checks++; if (bm.load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bm.load_ready); end
    checks++; if (bm.q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", bm.q); end
    checks++; if ({bm.serial_out, bm.serial_valid, bm.busy, bm.done} !== 4'b0000) begin errors++; $display("FAIL reset_outs got %b exp 0000", {bm.serial_out, bm.serial_valid, bm.busy, bm.done}); end
    checks++; if ({bl.load_ready, bl.serial_valid, bl.busy, bl.done} !== 4'b1000) begin errors++; $display("FAIL reset_lsb got %b exp 1000", {bl.load_ready, bl.serial_valid, bl.busy, bl.done}); end
    clear = 0;
    step();
  endtask

  task automatic test_msb();
    logic [7:0] tx = 8'b10110010;
    bm.d = 8'hB2; bm.load_valid = 1;
    step();
    bm.load_valid = 0; bm.d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bm.serial_valid !== 1'b1 || bm.serial_out !== tx[7-i]) begin errors++; $display("FAIL msb_bit%0d got v=%b b=%b exp v=1 b=%b", i, bm.serial_valid, bm.serial_out, tx[7-i]); end
      checks++; if (bm.done !== 1'b0 || bm.load_ready !== 1'b0) begin errors++; $display("FAIL msb_busy%0d got done=%b ready=%b exp 0 0", i, bm.done, bm.load_ready); end
      step();
    end
    checks++; if ({bm.done, bm.busy, bm.serial_valid, bm.load_ready} !== 4'b1100) begin errors++; $display("FAIL msb_done got %b exp 1100", {bm.done, bm.busy, bm.serial_valid, bm.load_ready}); end
    checks++; if (bm.q !== 8'hB2) begin errors++; $display("FAIL msb_q got %h exp b2", bm.q); end
    step();
    checks++; if ({bm.load_ready, bm.done, bm.busy} !== 3'b100) begin errors++; $display("FAIL msb_idle got %b exp 100", {bm.load_ready, bm.done, bm.busy}); end
  endtask

  task automatic test_lsb();
    logic [7:0] tx = 8'b10000000;
    bl.d = 8'h01; bl.load_valid = 1;
    step();
    bl.load_valid = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bl.serial_valid !== 1'b1 || bl.serial_out !== tx[7-i]) begin errors++; $display("FAIL lsb_bit%0d got v=%b b=%b exp v=1 b=%b", i, bl.serial_valid, bl.serial_out, tx[7-i]); end
      step();
    end
    checks++; if ({bl.done, bl.serial_valid, bl.serial_out} !== 3'b100) begin errors++; $display("FAIL lsb_done got %b exp 100", {bl.done, bl.serial_valid, bl.serial_out}); end
    step();
    checks++; if ({bl.load_ready, bl.done} !== 2'b10) begin errors++; $display("FAIL lsb_idle got %b exp 10", {bl.load_ready, bl.done}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tx = 8'b01010101;
    bm.d = 8'hFF; bm.load_valid = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) bm.d = 8'h55;
      checks++; if (bm.serial_out !== 1'b1 || bm.q !== 8'hFF) begin errors++; $display("FAIL hold_ff_bit%0d got b=%b q=%h exp b=1 q=ff", i, bm.serial_out, bm.q); end
      step();
    end
    checks++; if (bm.done !== 1'b1 || bm.q !== 8'hFF) begin errors++; $display("FAIL hold_done got done=%b q=%h exp 1 ff", bm.done, bm.q); end
    step();
    checks++; if (bm.load_ready !== 1'b1 || bm.q !== 8'hFF) begin errors++; $display("FAIL hold_idle got ready=%b q=%h exp 1 ff", bm.load_ready, bm.q); end
    step();
    bm.load_valid = 0;
    checks++; if (bm.q !== 8'h55) begin errors++; $display("FAIL hold_q55 got %h exp 55", bm.q); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bm.serial_valid !== 1'b1 || bm.serial_out !== tx[7-i]) begin errors++; $display("FAIL hold_55_bit%0d got v=%b b=%b exp v=1 b=%b", i, bm.serial_valid, bm.serial_out, tx[7-i]); end
      step();
    end
    checks++; if (bm.done !== 1'b1) begin errors++; $display("FAIL hold_55_done got %b exp 1", bm.done); end
    step();
  endtask

  task automatic test_abort();
    bm.d = 8'hF0; bm.load_valid = 1;
    step();
    bm.load_valid = 0;
    step(); step(); step();
    checks++; if (bm.serial_valid !== 1'b1 || bm.serial_out !== 1'b1) begin errors++; $display("FAIL abort_bit3 got v=%b b=%b exp 1 1", bm.serial_valid, bm.serial_out); end
    bm.abort = 1;
    step();
    bm.abort = 0;
    checks++; if ({bm.serial_valid, bm.serial_out, bm.busy, bm.done, bm.load_ready} !== 5'b00001) begin errors++; $display("FAIL abort_idle got %b exp 00001", {bm.serial_valid, bm.serial_out, bm.busy, bm.done, bm.load_ready}); end
    checks++; if (bm.q !== 8'hF0) begin errors++; $display("FAIL abort_q got %h exp f0", bm.q); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (bm.done !== 1'b0 || bm.load_ready !== 1'b1) begin errors++; $display("FAIL abort_nodone%0d got done=%b ready=%b exp 0 1", i, bm.done, bm.load_ready); end
    end
  endtask

  task automatic test_clear();
    logic [7:0] tx = 8'b10101010;
    bm.d = 8'hC3; bm.load_valid = 1;
    step();
    bm.load_valid = 0;
    step(); step(); step(); step();
    checks++; if (bm.serial_valid !== 1'b1 || bm.serial_out !== 1'b0) begin errors++; $display("FAIL clear_bit4 got v=%b b=%b exp 1 0", bm.serial_valid, bm.serial_out); end
    #5 clear = 1;
    #1;
    checks++; if ({bm.load_ready, bm.serial_valid, bm.serial_out, bm.busy, bm.done} !== 5'b10000) begin errors++; $display("FAIL clear_async got %b exp 10000", {bm.load_ready, bm.serial_valid, bm.serial_out, bm.busy, bm.done}); end
    checks++; if (bm.q !== 8'h00) begin errors++; $display("FAIL clear_q got %h exp 00", bm.q); end
    step();
    clear = 0;
    step();
    checks++; if (bm.done !== 1'b0) begin errors++; $display("FAIL clear_nodone got %b exp 0", bm.done); end
    bm.d = 8'hAA; bm.load_valid = 1;
    step();
    bm.load_valid = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bm.serial_valid !== 1'b1 || bm.serial_out !== tx[7-i]) begin errors++; $display("FAIL clear_aa_bit%0d got v=%b b=%b exp v=1 b=%b", i, bm.serial_valid, bm.serial_out, tx[7-i]); end
      step();
    end
    checks++; if (bm.done !== 1'b1 || bm.q !== 8'hAA) begin errors++; $display("FAIL clear_aa_done got done=%b q=%h exp 1 aa", bm.done, bm.q); end
    step();
  endtask

  initial begin
    test_reset();
    test_msb();
    test_lsb();
    test_back_to_back();
    test_abort();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
